// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Package : wb_pkg
// Brief   : Shared types and constants for the write-back stage
//           (write-back source select, load func3 codes, FIFO entry layout).
// Rev     : 1.0  initial release
// ============================================================================
package wb_pkg;

  // Natural register width of the core; the stage's default data width.
  localparam int WB_XLEN = 32;

  // Write-back source select; the unused code 2'b11 falls back to the ALU.
  typedef enum logic [1:0] {
    WB_ALU = 2'b00,
    WB_MEM = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_e;

  // Load size/sign codes carried in func3.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Canonical write-back entry at the core's natural width; wb_stage keeps
  // an identical layout sized by its XLEN parameter.
  typedef struct packed {
    logic               we;
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module  : load_align
// Brief   : Combinational load data alignment; picks the byte/halfword
//           addressed by the low address bits and sign/zero extends it.
// Rev     : 1.0  initial release
// ============================================================================
module load_align
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_addr_lo,
  input  logic [2:0]      i_func3,
  output logic [XLEN-1:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte/halfword and extend it according to func3.
  always_comb begin
    w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_func3)
      F3_LB:   o_data = {{(XLEN-8){w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{(XLEN-16){w_half[15]}}, w_half};
      F3_LBU:  o_data = {{(XLEN-8){1'b0}}, w_byte};
      F3_LHU:  o_data = {{(XLEN-16){1'b0}}, w_half};
      default: o_data = i_rdata;  // LW and undefined codes pass the word
    endcase
  end

endmodule : load_align
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : wb_stage
// Brief   : Write-back stage. Execute results queue in a 2-entry FIFO
//           (load alignment applied on entry), MUL/DIV results use a 1-entry
//           holding register with priority; one registered write per cycle.
// Config  : WB_STAGE_FWD_EN - when defined, fwd_* mirror the write port;
//           otherwise fwd_* are tied to zero.
// Rev     : 1.0  initial release
// ============================================================================
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN = WB_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            ex_reg_write,
  input  logic [4:0]      ex_rd,
  input  logic [1:0]      ex_wb_sel,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic [XLEN-1:0] ex_mem_rdata,
  input  logic [1:0]      ex_addr_lo,
  input  logic [2:0]      ex_func3,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_result,
  output logic            wr_en,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] write_data,
  output logic            fwd_valid,
  output logic [4:0]      fwd_rd,
  output logic [XLEN-1:0] fwd_data
);

  typedef struct packed {
    logic            we;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  // Execute FIFO
  ent_t            r_fifo [2];
  logic            r_wr_ptr;
  logic            r_rd_ptr;
  logic [1:0]      r_count;
  logic            r_ex_ready;

  // MUL/DIV holding register
  logic            r_hold_vld;
  logic [4:0]      r_hold_rd;
  logic [XLEN-1:0] r_hold_data;
  logic            r_md_ready;

  // Registered write port
  logic            r_wr_en;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;

  logic            w_ex_acc;
  logic            w_md_acc;
  logic            w_pop;
  logic [1:0]      w_count_nxt;
  logic [XLEN-1:0] w_aligned;
  logic [XLEN-1:0] w_sel_data;
  ent_t            w_push_ent;
  ent_t            w_head;

  load_align #(.XLEN(XLEN)) u_load_align (
    .i_rdata   (ex_mem_rdata),
    .i_addr_lo (ex_addr_lo),
    .i_func3   (ex_func3),
    .o_data    (w_aligned)
  );

  assign w_ex_acc    = ex_valid & r_ex_ready;
  assign w_md_acc    = md_valid & r_md_ready;
  // The holding register owns the write port whenever it is occupied.
  assign w_pop       = (r_count != 2'd0) & ~r_hold_vld;
  assign w_count_nxt = r_count + {1'b0, w_ex_acc} - {1'b0, w_pop};
  assign w_head      = r_fifo[r_rd_ptr];

  // Build the FIFO entry with its final write value so the write port only muxes.
  always_comb begin
    case (wb_sel_e'(ex_wb_sel))
      WB_MEM:  w_sel_data = w_aligned;
      WB_PC4:  w_sel_data = ex_pc_plus4;
      default: w_sel_data = ex_alu_result;  // WB_ALU and the unused code
    endcase
    w_push_ent.we   = ex_reg_write & (ex_rd != 5'd0);
    w_push_ent.rd   = ex_rd;
    w_push_ent.data = w_sel_data;
  end

  // FIFO storage, pointers, occupancy and the registered ex_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_ex_ready <= 1'b0;
    end else begin
      if (w_ex_acc) begin
        r_fifo[r_wr_ptr] <= w_push_ent;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_nxt;
      r_ex_ready <= (w_count_nxt != 2'd2);
    end
  end

  // Holding register: drains every cycle it is full, so it is empty next
  // cycle unless a new result is accepted now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld  <= 1'b0;
      r_hold_rd   <= 5'd0;
      r_hold_data <= '0;
      r_md_ready  <= 1'b0;
    end else begin
      if (w_md_acc) begin
        r_hold_vld  <= 1'b1;
        r_hold_rd   <= md_rd;
        r_hold_data <= md_result;
      end else if (r_hold_vld) begin
        r_hold_vld  <= 1'b0;
      end
      r_md_ready <= ~w_md_acc;
    end
  end

  // Register-file write port; non-writing entries drive an all-zero port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en <= 1'b0;
      r_rd    <= 5'd0;
      r_wdata <= '0;
    end else if (r_hold_vld) begin
      r_wr_en <= (r_hold_rd != 5'd0);
      r_rd    <= r_hold_rd;
      r_wdata <= (r_hold_rd != 5'd0) ? r_hold_data : '0;
    end else if (w_pop) begin
      r_wr_en <= w_head.we;
      r_rd    <= w_head.we ? w_head.rd : 5'd0;
      r_wdata <= w_head.we ? w_head.data : '0;
    end else begin
      r_wr_en <= 1'b0;
      r_rd    <= 5'd0;
      r_wdata <= '0;
    end
  end

  assign ex_ready   = r_ex_ready;
  assign md_ready   = r_md_ready;
  assign wr_en      = r_wr_en;
  assign rd         = r_rd;
  assign write_data = r_wdata;

`ifdef WB_STAGE_FWD_EN
  assign fwd_valid = r_wr_en;
  assign fwd_rd    = r_rd;
  assign fwd_data  = r_wdata;
`else
  assign fwd_valid = 1'b0;
  assign fwd_rd    = 5'd0;
  assign fwd_data  = '0;
`endif

endmodule : wb_stage
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_stage
// Brief   : Self-checking bench for wb_stage: table of single-entry write
//           values, hand sequences for ordering/back-pressure/reset, and a
//           randomized run against a queue-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wb_stage;
  import wb_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ex_valid = 1'b0;
  logic            ex_ready;
  logic            ex_reg_write = 1'b0;
  logic [4:0]      ex_rd = '0;
  logic [1:0]      ex_wb_sel = '0;
  logic [XLEN-1:0] ex_alu_result = '0;
  logic [XLEN-1:0] ex_pc_plus4 = '0;
  logic [XLEN-1:0] ex_mem_rdata = '0;
  logic [1:0]      ex_addr_lo = '0;
  logic [2:0]      ex_func3 = '0;
  logic            md_valid = 1'b0;
  logic            md_ready;
  logic [4:0]      md_rd = '0;
  logic [XLEN-1:0] md_result = '0;
  logic            wr_en;
  logic [4:0]      rd;
  logic [XLEN-1:0] write_data;
  logic            fwd_valid;
  logic [4:0]      fwd_rd;
  logic [XLEN-1:0] fwd_data;

  wb_stage #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_reg_write  (ex_reg_write),
    .ex_rd         (ex_rd),
    .ex_wb_sel     (ex_wb_sel),
    .ex_alu_result (ex_alu_result),
    .ex_pc_plus4   (ex_pc_plus4),
    .ex_mem_rdata  (ex_mem_rdata),
    .ex_addr_lo    (ex_addr_lo),
    .ex_func3      (ex_func3),
    .md_valid      (md_valid),
    .md_ready      (md_ready),
    .md_rd         (md_rd),
    .md_result     (md_result),
    .wr_en         (wr_en),
    .rd            (rd),
    .write_data    (write_data),
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Write port (and bypass) against an expected write; rd/data only matter when writing.
  task automatic chk_port(input string nm, input logic we, input logic [4:0] erd,
                          input logic [31:0] ed);
    chk({nm, " wr_en"}, {31'd0, wr_en}, {31'd0, we});
    if (we) begin
      chk({nm, " rd"}, {27'd0, rd}, {27'd0, erd});
      chk({nm, " write_data"}, write_data, ed);
    end
`ifdef WB_STAGE_FWD_EN
    chk({nm, " fwd_valid"}, {31'd0, fwd_valid}, {31'd0, we});
    if (we) begin
      chk({nm, " fwd_rd"}, {27'd0, fwd_rd}, {27'd0, erd});
      chk({nm, " fwd_data"}, fwd_data, ed);
    end
`else
    chk({nm, " fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    chk({nm, " fwd_rd"}, {27'd0, fwd_rd}, 32'd0);
    chk({nm, " fwd_data"}, fwd_data, 32'd0);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [1:0] sel, input logic [2:0] f3, input logic [1:0] a,
                          input logic [31:0] rdat, input logic [31:0] alu,
                          input logic [31:0] pc4, input logic [4:0] r, input logic rw);
    ex_valid      = 1'b1;
    ex_wb_sel     = sel;
    ex_func3      = f3;
    ex_addr_lo    = a;
    ex_mem_rdata  = rdat;
    ex_alu_result = alu;
    ex_pc_plus4   = pc4;
    ex_rd         = r;
    ex_reg_write  = rw;
  endtask

  // Expected write value from the load/select rules, using plain shifts and masks.
  function automatic logic [31:0] ref_val(input logic [1:0] sel, input logic [2:0] f3,
                                          input logic [1:0] a, input logic [31:0] rdat,
                                          input logic [31:0] alu, input logic [31:0] pc4);
    logic [31:0] b;
    logic [31:0] h;
    if (sel == 2'b10) return pc4;
    if (sel != 2'b01) return alu;
    b = (rdat >> (8 * a)) & 32'hFF;
    h = (rdat >> (16 * a[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return rdat;
    endcase
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] rdat;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [4:0]  r;
    logic        rw;
    logic        exp_we;
    logic [31:0] exp_d;
    string       nm;
  } vec_t;

  vec_t vt [17];

  // Reference model state: queue for the execute FIFO, one slot for MUL/DIV.
  typedef struct {
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
  } ment_t;

  ment_t       mq[$];
  logic        m_hv;
  logic [4:0]  m_hrd;
  logic [31:0] m_hd;
  logic        m_exr;
  logic        m_mdr;
  logic        e_we;
  logic [4:0]  e_rd;
  logic [31:0] e_d;

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic model_edge();
    bit    acc_ex;
    bit    acc_md;
    ment_t x;
    acc_ex = ex_valid && m_exr;
    acc_md = md_valid && m_mdr;
    e_we = 1'b0; e_rd = '0; e_d = '0;
    if (m_hv) begin
      e_we = (m_hrd != 0); e_rd = m_hrd; e_d = m_hd;
      m_hv = 1'b0;
    end else if (mq.size() > 0) begin
      x = mq.pop_front();
      e_we = x.we; e_rd = x.r; e_d = x.d;
    end
    if (acc_md) begin
      m_hv = 1'b1; m_hrd = md_rd; m_hd = md_result;
    end
    if (acc_ex) begin
      x.we = ex_reg_write && (ex_rd != 0);
      x.r  = ex_rd;
      x.d  = ref_val(ex_wb_sel, ex_func3, ex_addr_lo, ex_mem_rdata, ex_alu_result, ex_pc_plus4);
      mq.push_back(x);
    end
    m_exr = (mq.size() < 2);
    m_mdr = !m_hv;
  endtask

  initial begin
    vt[0]  = '{2'b01, 3'b000, 2'd1, 32'h1234_80FF, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 32'hFFFF_FF80, "LB"};
    vt[1]  = '{2'b01, 3'b100, 2'd1, 32'h1234_80FF, 32'h0, 32'h0, 5'd5, 1'b1, 1'b1, 32'h0000_0080, "LBU"};
    vt[2]  = '{2'b01, 3'b001, 2'd2, 32'h8001_0000, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 32'hFFFF_8001, "LH_hi"};
    vt[3]  = '{2'b01, 3'b101, 2'd2, 32'h8001_0000, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 32'h0000_8001, "LHU_hi"};
    vt[4]  = '{2'b01, 3'b001, 2'd0, 32'h1234_7FFE, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 32'h0000_7FFE, "LH_pos"};
    vt[5]  = '{2'b01, 3'b001, 2'd1, 32'h0000_9000, 32'h0, 32'h0, 5'd8, 1'b1, 1'b1, 32'hFFFF_9000, "LH_a1"};
    vt[6]  = '{2'b01, 3'b010, 2'd0, 32'hCAFE_BABE, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 32'hCAFE_BABE, "LW"};
    vt[7]  = '{2'b01, 3'b011, 2'd2, 32'h1122_3344, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1, 32'h1122_3344, "F3_011"};
    vt[8]  = '{2'b01, 3'b110, 2'd1, 32'h99AA_BBCC, 32'h0, 32'h0, 5'd11, 1'b1, 1'b1, 32'h99AA_BBCC, "F3_110"};
    vt[9]  = '{2'b01, 3'b000, 2'd3, 32'h8000_0000, 32'h0, 32'h0, 5'd12, 1'b1, 1'b1, 32'hFFFF_FF80, "LB_a3"};
    vt[10] = '{2'b01, 3'b000, 2'd2, 32'h1234_5678, 32'h0, 32'h0, 5'd13, 1'b1, 1'b1, 32'h0000_0034, "LB_a2"};
    vt[11] = '{2'b01, 3'b101, 2'd0, 32'h1234_F00D, 32'h0, 32'h0, 5'd14, 1'b1, 1'b1, 32'h0000_F00D, "LHU_lo"};
    vt[12] = '{2'b00, 3'b000, 2'd0, 32'h0, 32'h1111_2222, 32'h0, 5'd31, 1'b1, 1'b1, 32'h1111_2222, "ALU"};
    vt[13] = '{2'b10, 3'b000, 2'd0, 32'h0, 32'h0000_5555, 32'h0000_0104, 5'd1, 1'b1, 1'b1, 32'h0000_0104, "JAL"};
    vt[14] = '{2'b11, 3'b000, 2'd0, 32'h0, 32'hABCD_0000, 32'h0000_0001, 5'd2, 1'b1, 1'b1, 32'hABCD_0000, "SEL11"};
    vt[15] = '{2'b00, 3'b000, 2'd0, 32'h0, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b1, 1'b0, 32'h0, "rd0"};
    vt[16] = '{2'b00, 3'b000, 2'd0, 32'h0, 32'h0000_1234, 32'h0, 5'd3, 1'b0, 1'b0, 32'h0, "nowrite"};

    // Reset state
    @(posedge clk); step();
    chk_port("reset", 1'b0, 5'd0, 32'd0);
    chk("reset ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("reset md_ready", {31'd0, md_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("release ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("release md_ready", {31'd0, md_ready}, 32'd1);

    // Single-entry table
    for (int i = 0; i < 17; i++) begin
      drive_ex(vt[i].sel, vt[i].f3, vt[i].a, vt[i].rdat, vt[i].alu, vt[i].pc4, vt[i].r, vt[i].rw);
      step();
      chk_port({vt[i].nm, " early"}, 1'b0, 5'd0, 32'd0);
      ex_valid = 1'b0;
      step();
      chk_port(vt[i].nm, vt[i].exp_we, vt[i].r, vt[i].exp_d);
    end

    // Three back-to-back ALU results
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hA000_0001, 32'h0, 5'd20, 1'b1);
    step();
    chk("b2b ready0", {31'd0, ex_ready}, 32'd1);
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hA000_0002, 32'h0, 5'd21, 1'b1);
    step();
    chk_port("b2b w1", 1'b1, 5'd20, 32'hA000_0001);
    chk("b2b ready1", {31'd0, ex_ready}, 32'd1);
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hA000_0003, 32'h0, 5'd22, 1'b1);
    step();
    chk_port("b2b w2", 1'b1, 5'd21, 32'hA000_0002);
    chk("b2b ready2", {31'd0, ex_ready}, 32'd1);
    ex_valid = 1'b0;
    step();
    chk_port("b2b w3", 1'b1, 5'd22, 32'hA000_0003);
    step();
    chk_port("b2b idle", 1'b0, 5'd0, 32'd0);

    // MUL/DIV priority with two ALU entries queued, back-pressure on a third
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hB000_000A, 32'h0, 5'd10, 1'b1);
    md_valid = 1'b1; md_rd = 5'd7; md_result = 32'h7777_0001;
    step();
    chk("prio md_ready0", {31'd0, md_ready}, 32'd0);
    md_valid = 1'b0;
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hB000_000B, 32'h0, 5'd11, 1'b1);
    step();
    chk_port("prio md", 1'b1, 5'd7, 32'h7777_0001);
    chk("prio full ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("prio md_ready1", {31'd0, md_ready}, 32'd1);
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hB000_000C, 32'h0, 5'd12, 1'b1);
    step();
    chk_port("prio A", 1'b1, 5'd10, 32'hB000_000A);
    chk("prio ex_ready back", {31'd0, ex_ready}, 32'd1);
    step();
    chk_port("prio B", 1'b1, 5'd11, 32'hB000_000B);
    ex_valid = 1'b0;
    step();
    chk_port("prio C", 1'b1, 5'd12, 32'hB000_000C);
    step();
    chk_port("prio idle", 1'b0, 5'd0, 32'd0);

    // Reset with entries in flight in both the FIFO and the holding register
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hC000_000D, 32'h0, 5'd13, 1'b1);
    md_valid = 1'b1; md_rd = 5'd14; md_result = 32'hC000_000E;
    step();
    md_rd = 5'd15; md_result = 32'hC000_000F;
    drive_ex(2'b00, 3'b0, 2'd0, 32'h0, 32'hC000_0010, 32'h0, 5'd16, 1'b1);
    step();
    ex_valid = 1'b0;
    step();
    md_valid = 1'b0;
    chk_port("rst pre", 1'b1, 5'd13, 32'hC000_000D);
    rst_n = 1'b0;
    #1;
    chk("rst async wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst async rd", {27'd0, rd}, 32'd0);
    chk("rst async data", write_data, 32'd0);
    chk("rst async ex_ready", {31'd0, ex_ready}, 32'd0);
    chk("rst async md_ready", {31'd0, md_ready}, 32'd0);
    chk("rst async fwd_valid", {31'd0, fwd_valid}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst rel ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst rel md_ready", {31'd0, md_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk_port("rst no stale", 1'b0, 5'd0, 32'd0);
      step();
    end

    // Randomized traffic against the reference model
    m_hv = 1'b0; m_hrd = '0; m_hd = '0; m_exr = 1'b1; m_mdr = 1'b1;
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      if (!(ex_valid && !m_exr)) begin
        ex_valid = ($urandom_range(0, 9) < 7);
        drive_ex(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 $urandom, $urandom, $urandom,
                 ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                 ($urandom_range(0, 9) != 0));
        ex_valid = ($urandom_range(0, 9) < 7);
      end
      if (!(md_valid && !m_mdr)) begin
        md_valid  = ($urandom_range(0, 9) < 3);
        md_rd     = 5'($urandom_range(0, 31));
        md_result = $urandom;
      end
      model_edge();
      step();
      chk_port("rand", e_we, e_rd, e_d);
      chk("rand ex_ready", {31'd0, ex_ready}, {31'd0, m_exr});
      chk("rand md_ready", {31'd0, md_ready}, {31'd0, m_mdr});
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_wb_stage
`default_nettype wire
